uart_tx_frm: RTL

Parametrised UART transmitter, single-clock successor to the baud-clock-driven TX: bit timing is derived internally from the system clock, so no second clock domain exists. It supports configurable data width, stop-bit count and an optional parity bit. A one-entry holding register allows back-to-back frames with no idle gap. It sits between a byte source (FIFO or register interface) and the serial pin.

---
 rtl/uart_tx_frm.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_frm.sv
// uart_tx_frm: single-clock UART transmitter with a one-entry holding register.
// Bit timing comes from an internal divider on sysclk_in. Frame layout is
// start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop bits.
// Optional feature macro: UART_TX_PARITY_EN adds the parity bit
// (PARITY_ODD selects odd parity).
module uart_tx_frm #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 sysclk_in,
    input  logic                 nrst_in,
    input  logic                 data_valid_in,
    input  logic [DATA_BITS-1:0] tx_data_in,
    output logic                 data_ready_out,
    output logic                 tx_serial_out,
    output logic                 tx_busy_out,
    output logic                 tx_done_out
);

    localparam int DIV_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PAR   = 3'd3,
`endif
        ST_STOP  = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    // Even parity is the XOR of the word; odd parity is its complement.
    function automatic logic parity_f(input logic [DATA_BITS-1:0] word);
        logic p;
        p = ^word;
        return (PARITY_ODD != 0) ? ~p : p;
    endfunction
`endif

    state_t                 state_r, state_s;
    logic [DIV_W-1:0]       div_r, div_s;
    logic [IDX_W-1:0]       idx_r, idx_s;
    logic                   stop_cnt_r, stop_cnt_s;
    logic [DATA_BITS-1:0]   shift_r, shift_s;
    logic [DATA_BITS-1:0]   hold_r, hold_s;
    logic                   hold_full_r, hold_full_s;
    logic                   serial_r, serial_s;
    logic                   ready_r;
    logic                   busy_r, busy_s;
    logic                   done_r;
`ifdef UART_TX_PARITY_EN
    logic                   par_r, par_s;
`endif

    logic bit_end_s;
    logic end_frame_s;
    logic load_s;
    logic accept_s;

    // The shifter is free in IDLE or on the edge that closes the last stop bit.
    assign bit_end_s   = (div_r == DIV_LAST);
    assign end_frame_s = (state_r == ST_STOP) && bit_end_s && (stop_cnt_r == STOP_LAST);
    assign load_s      = hold_full_r && ((state_r == ST_IDLE) || end_frame_s);
    assign accept_s    = data_valid_in && ready_r;

    // Next-state, holding-register and line-level logic.
    always_comb begin
        state_s     = state_r;
        div_s       = div_r;
        idx_s       = idx_r;
        stop_cnt_s  = stop_cnt_r;
        shift_s     = shift_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
`ifdef UART_TX_PARITY_EN
        par_s       = par_r;
`endif

        if (load_s) begin
            // A load restarts the divider and opens a new frame.
            state_s = ST_START;
            div_s   = '0;
            shift_s = hold_r;
`ifdef UART_TX_PARITY_EN
            par_s   = parity_f(hold_r);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    div_s = '0;
                end
                ST_START: begin
                    if (bit_end_s) begin
                        state_s = ST_DATA;
                        idx_s   = '0;
                        div_s   = '0;
                    end else begin
                        div_s = div_r + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        div_s   = '0;
                        shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
                        if (idx_r == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_s = ST_PAR;
`else
                            state_s = ST_STOP;
`endif
                            stop_cnt_s = 1'b0;
                        end else begin
                            idx_s = idx_r + 1'b1;
                        end
                    end else begin
                        div_s = div_r + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PAR: begin
                    if (bit_end_s) begin
                        state_s    = ST_STOP;
                        stop_cnt_s = 1'b0;
                        div_s      = '0;
                    end else begin
                        div_s = div_r + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        div_s = '0;
                        if (stop_cnt_r == STOP_LAST) begin
                            state_s = ST_IDLE;
                        end else begin
                            stop_cnt_s = stop_cnt_r + 1'b1;
                        end
                    end else begin
                        div_s = div_r + 1'b1;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    div_s   = '0;
                end
            endcase
        end

        // An accept always writes the new word; a bare load just empties it.
        if (accept_s) begin
            hold_s      = tx_data_in;
            hold_full_s = 1'b1;
        end else if (load_s) begin
            hold_full_s = 1'b0;
        end else begin
            hold_full_s = hold_full_r;
        end

        case (state_s)
            ST_IDLE:  serial_s = 1'b1;
            ST_START: serial_s = 1'b0;
            ST_DATA:  serial_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PAR:   serial_s = par_s;
`endif
            ST_STOP:  serial_s = 1'b1;
            default:  serial_s = 1'b1;
        endcase

        busy_s = (state_s != ST_IDLE) || hold_full_s;
    end

    // State, datapath and registered outputs; reset aborts any frame silently.
    always_ff @(posedge sysclk_in or negedge nrst_in) begin
        if (!nrst_in) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            idx_r       <= '0;
            stop_cnt_r  <= 1'b0;
            shift_r     <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            serial_r    <= 1'b1;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            div_r       <= div_s;
            idx_r       <= idx_s;
            stop_cnt_r  <= stop_cnt_s;
            shift_r     <= shift_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            serial_r    <= serial_s;
            ready_r     <= ~hold_full_s;
            busy_r      <= busy_s;
            done_r      <= end_frame_s;
`ifdef UART_TX_PARITY_EN
            par_r       <= par_s;
`endif
        end
    end

    assign data_ready_out = ready_r;
    assign tx_serial_out  = serial_r;
    assign tx_busy_out    = busy_r;
    assign tx_done_out    = done_r;

endmodule
